// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack
//   Multi-cycle normaliser / rounder / packer for IEEE-754 results coming
//   out of the FP datapath. Normalisation runs one binary-search shift stage
//   per clock. Rounding is round-to-nearest, ties-to-even.
//
// States
//   IDLE  | waiting for an operand, in_ready high
//   PRE   | specials (NaN/Inf/zero) resolved, carry bit folded down
//   NORM  | one left-shift stage of 2^k per clock, k counts down to 0
//   ROUND | guard/sticky rounding, overflow/denormal packing
//   DONE  | result presented until out_ready
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake
//   in_sign, in_exp     sign and biased exponent of the hidden-bit position
//   in_man              magnitude: [EXT_BIT-1] carry, [EXT_BIT-2] hidden bit
//   in_nan, in_inf      force quiet NaN / signed infinity
//   out_valid/out_ready result handshake
//   out                 packed IEEE word
//   out_flags           {overflow, underflow, inexact}

module fp_normalize_pack #(
    parameter int LOG_BIT   = 5,
    parameter int EXP_BIT   = 8,
    parameter int N_BIT     = 1 << LOG_BIT,
    parameter int MAN_BIT   = N_BIT - EXP_BIT - 1,
    parameter int EXT_BIT   = 2 * MAN_BIT + 4,
    parameter int SH_STAGES = $clog2(EXT_BIT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_BIT:0]   in_exp,
    input  logic [EXT_BIT-1:0] in_man,
    input  logic               in_nan,
    input  logic               in_inf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BIT-1:0]   out,
    output logic [2:0]         out_flags
);

    // One bit of headroom above the input exponent width so the carry
    // increment of a maximal in_exp cannot wrap.
    localparam int EXPW = EXP_BIT + 2;
    localparam int KW   = (SH_STAGES > 1) ? $clog2(SH_STAGES) : 1;
    localparam int SW   = SH_STAGES + 1;
    localparam int RW   = EXPW + MAN_BIT;

    localparam logic [EXPW-1:0]  EXP_MAX   = EXPW'((1 << EXP_BIT) - 1);
    localparam logic [N_BIT-1:0] QNAN_WORD = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXPW-1:0]    exp_q, exp_d;
    logic [EXT_BIT-1:0] man_q, man_d;
    logic [KW-1:0]      k_q, k_d;
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
    logic [N_BIT-1:0]   out_q, out_d;
    logic [2:0]         flags_q, flags_d;

    // Normalise stage helpers: s = 2^k, and a mask covering the top s bits
    // from the hidden position downward.
    logic [SW-1:0]      s_sh;
    logic [EXPW-1:0]    s_exp;
    logic [EXT_BIT-2:0] norm_mask;
    logic               top_zero;

    assign s_sh      = SW'(1) << k_q;
    assign s_exp     = EXPW'(s_sh);
    assign norm_mask = ~({(EXT_BIT-1){1'b1}} >> s_sh);
    assign top_zero  = (man_q[EXT_BIT-2:0] & norm_mask) == '0;

    // Rounding helpers
    logic               hid;
    logic [MAN_BIT-1:0] frac;
    logic               guard;
    logic               sticky;
    logic               inc;
    logic [EXPW-1:0]    exp_field;
    logic [RW-1:0]      rsum;
    logic [EXPW-1:0]    rexp;
    logic               ovf;

    assign hid       = man_q[EXT_BIT-2];
    assign frac      = man_q[EXT_BIT-3 -: MAN_BIT];
    assign guard     = man_q[EXT_BIT-3-MAN_BIT];
    assign sticky    = |man_q[EXT_BIT-4-MAN_BIT:0];
    assign inc       = guard & (frac[0] | sticky);
    assign exp_field = hid ? exp_q : '0;
    // Increment on the joined {exponent, fraction}: a fraction carry bumps
    // the exponent, and a denormal carry becomes the smallest normal.
    assign rsum      = {exp_field, frac} + RW'(inc);
    assign rexp      = rsum[RW-1 -: EXPW];
    assign ovf       = rexp >= EXP_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            k_q     <= '0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            k_q     <= k_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        k_d     = k_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        out_d   = out_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = EXPW'(in_exp);
                    man_d   = in_man;
                    nan_d   = in_nan;
                    inf_d   = in_inf;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (nan_q) begin
                    out_d   = QNAN_WORD;
                    flags_d = '0;
                    state_d = DONE;
                end else if (inf_q) begin
                    out_d   = {sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
                    flags_d = '0;
                    state_d = DONE;
                end else if (man_q == '0) begin
                    out_d   = {sign_q, {(N_BIT-1){1'b0}}};
                    flags_d = '0;
                    state_d = DONE;
                end else begin
                    if (man_q[EXT_BIT-1]) begin
                        // Keep the dropped bit alive as sticky in bit 0.
                        man_d = {1'b0, man_q[EXT_BIT-1:2], man_q[1] | man_q[0]};
                        exp_d = exp_q + EXPW'(1);
                    end
                    k_d     = KW'(SH_STAGES - 1);
                    state_d = NORM;
                end
            end
            NORM: begin
                // The exp > s guard stops at exponent 1, leaving a denormal.
                if (top_zero && (exp_q > s_exp)) begin
                    man_d = man_q << s_sh;
                    exp_d = exp_q - s_exp;
                end
                if (k_q == '0) begin
                    state_d = ROUND;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            ROUND: begin
                if (ovf) begin
                    out_d = {sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
                end else begin
                    out_d = {sign_q, rexp[EXP_BIT-1:0], rsum[MAN_BIT-1:0]};
                end
                flags_d = {ovf, (!ovf) && (rexp == '0), guard | sticky | ovf};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
module tb_fp_normalize_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [49:0] in_man;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;

    fp_normalize_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: normalise by the smaller of the leading-zero count and the
    // room left above exponent 1, then round-nearest-even on the packed word.
    function automatic void model(input logic s, input logic [8:0] ex, input logic [49:0] mn,
                                  input logic nn, input logic nf,
                                  output logic [31:0] o, output logic [2:0] f, output int lat);
        logic [63:0] m;
        longint e, sh, field, frac, v, fe;
        int lz;
        logic g, st, lsb;
        lat = 1;
        f   = 3'b000;
        if (nn) o = 32'h7FC00000;
        else if (nf) o = {s, 8'hFF, 23'h0};
        else if (mn == 0) o = {s, 31'h0};
        else begin
            lat = 8;
            m = 64'(mn);
            e = longint'(ex);
            if (m[49]) begin
                m = (m >> 1) | (m & 64'd1);
                e = e + 1;
            end
            lz = 0;
            while (lz < 49 && !m[48-lz]) lz++;
            sh = lz;
            if (sh > e - 1) sh = e - 1;
            if (sh < 0) sh = 0;
            m = m << sh;
            e = e - sh;
            field = m[48] ? e : 0;
            frac  = longint'((m >> 25) & 64'h7FFFFF);
            g     = m[24];
            st    = (m & 64'hFFFFFF) != 0;
            lsb   = m[25];
            v  = field * 8388608 + frac + ((g && (lsb || st)) ? 1 : 0);
            fe = v / 8388608;
            if (fe >= 255) begin
                o = {s, 8'hFF, 23'h0};
                f = 3'b101;
            end else begin
                o = {s, 8'(fe), 23'(v % 8388608)};
                f = {1'b0, fe == 0, g || st};
            end
        end
    endfunction

    // Compare process: track each accepted operand and check every valid cycle.
    logic [31:0] exp_o;
    logic [2:0]  exp_f;
    int          exp_lat;
    int          since;
    bit          active  = 0;
    bit          lat_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
        end else begin
            if (in_valid && in_ready) begin
                model(in_sign, in_exp, in_man, in_nan, in_inf, exp_o, exp_f, exp_lat);
                active   = 1;
                since    = -1;
                lat_done = 0;
            end else if (active) begin
                since++;
            end
            if (out_valid) begin
                if (!active) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!lat_done) begin
                        chk("latency", 32'(since), 32'(exp_lat));
                        lat_done = 1;
                    end
                    chk("model_out", out, exp_o);
                    chk("model_flags", 32'(out_flags), 32'(exp_f));
                    if (out_ready) active = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic s, input logic [8:0] e, input logic [49:0] m,
                          input logic nn, input logic nf,
                          input logic [31:0] lo, input logic [2:0] lf, input int hold);
        int n;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 30) begin tick(); n++; end
        if (!in_ready) chk({nm, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_sign = s; in_exp = e; in_man = m; in_nan = nn; in_inf = nf;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        if (!out_valid) chk({nm, "_valid_timeout"}, 32'(out_valid), 32'd1);
        chk({nm, "_out"}, out, lo);
        chk({nm, "_flags"}, 32'(out_flags), 32'(lf));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                in_valid = 1'b1;
                in_nan   = 1'b1;
                tick();
                chk({nm, "_hold_out"}, out, lo);
                chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            end
            in_valid  = 1'b0;
            in_nan    = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
        in_nan = 1'b0; in_inf = 1'b0;
    endtask

    localparam logic [49:0] ONE = 50'd1;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
        in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        run_op("one",        0, 9'd127, ONE << 48,                              0, 0, 32'h3F800000, 3'b000, 0);
        run_op("carry",      0, 9'd127, (ONE << 49) | (ONE << 48),              0, 0, 32'h40400000, 3'b000, 0);
        run_op("norm8",      0, 9'd127, ONE << 40,                              0, 0, 32'h3B800000, 3'b000, 0);
        run_op("tie_even",   0, 9'd127, (ONE << 48) | (ONE << 24),              0, 0, 32'h3F800000, 3'b001, 0);
        run_op("tie_odd",    0, 9'd127, (ONE << 48) | (ONE << 25) | (ONE << 24), 0, 0, 32'h3F800002, 3'b001, 0);
        run_op("frac_carry", 0, 9'd127, (ONE << 48) | (50'h7FFFFF << 25) | (ONE << 24), 0, 0, 32'h40000000, 3'b001, 0);
        run_op("sticky_shr", 0, 9'd127, (ONE << 49) | ONE,                      0, 0, 32'h40000000, 3'b001, 0);
        run_op("overflow",   0, 9'd254, (ONE << 49) | (ONE << 48),              0, 0, 32'h7F800000, 3'b101, 0);
        run_op("big_exp",    0, 9'd300, ONE << 48,                              0, 0, 32'h7F800000, 3'b101, 0);
        run_op("denorm",     0, 9'd1,   ONE << 47,                              0, 0, 32'h00400000, 3'b010, 0);
        run_op("denorm_sh",  0, 9'd5,   ONE << 40,                              0, 0, 32'h00080000, 3'b010, 0);
        run_op("den_promo",  0, 9'd1,   (50'h7FFFFF << 25) | (ONE << 24),       0, 0, 32'h00800000, 3'b001, 0);
        run_op("neg12",      1, 9'd130, (ONE << 48) | (ONE << 47),              0, 0, 32'hC1400000, 3'b000, 0);
        run_op("nan",        0, 9'd0,   50'd0,                                  1, 0, 32'h7FC00000, 3'b000, 0);
        run_op("nan_prio",   1, 9'd10,  ONE << 48,                              1, 1, 32'h7FC00000, 3'b000, 0);
        run_op("neg_inf",    1, 9'd0,   50'd0,                                  0, 1, 32'hFF800000, 3'b000, 0);
        run_op("neg_zero",   1, 9'd50,  50'd0,                                  0, 0, 32'h80000000, 3'b000, 0);
        run_op("hold",       0, 9'd127, (ONE << 48) | (ONE << 25) | (ONE << 24), 0, 0, 32'h3F800002, 3'b001, 5);
        repeat (3) tick();

        // Abort in the middle of normalisation.
        in_sign = 1'b0; in_exp = 9'd127; in_man = ONE << 40; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out", out, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_op("after_abort", 0, 9'd127, ONE << 48, 0, 0, 32'h3F800000, 3'b000, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
